// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: handshake bundle around the immediate-generation stage.
//   Upstream:   in_valid_i, in_ready_o, instr_i (32-bit instruction word)
//   Downstream: out_valid_o, out_ready_i, imm_o (XLEN), fmt_o (3), illegal_o
//   slave  - stage side (consumes instructions, produces decoded results)
//   master - environment side (drives instructions, accepts results)
interface imm_gen_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] imm_o;
    logic [2:0]      fmt_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, instr_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o
    );

    modport master (
        output in_valid_i, instr_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decodes the immediate of an RV32/RV64 base instruction and
// buffers {imm, fmt, illegal} in a 2-entry FIFO with valid/ready handshakes.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (empties the FIFO)
//   bus   - imm_gen_stage_if slave modport (upstream + downstream handshakes)
// fmt codes: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7.
module imm_gen_stage #(
    parameter int unsigned XLEN    = 32,
    parameter bit          ZIMM_EN = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    imm_gen_stage_if.slave bus
);
    localparam logic [2:0] FmtI    = 3'd0;
    localparam logic [2:0] FmtS    = 3'd1;
    localparam logic [2:0] FmtB    = 3'd2;
    localparam logic [2:0] FmtU    = 3'd3;
    localparam logic [2:0] FmtJ    = 3'd4;
    localparam logic [2:0] FmtZ    = 3'd5;
    localparam logic [2:0] FmtNone = 3'd7;

    logic [31:0]     instr;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    assign instr = bus.instr_i;

    // Decode happens before storage; signed casts perform the sign extension.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FmtNone;
        dec_ill = 1'b1;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt = FmtI;
                dec_ill = 1'b0;
                dec_imm = XLEN'($signed(instr[31:20]));
            end
            7'b0100011: begin
                dec_fmt = FmtS;
                dec_ill = 1'b0;
                dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FmtB;
                dec_ill = 1'b0;
                dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FmtU;
                dec_ill = 1'b0;
                dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_fmt = FmtJ;
                dec_ill = 1'b0;
                dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            7'b1110011: begin
                if (ZIMM_EN) begin
                    dec_fmt = FmtZ;
                    dec_ill = 1'b0;
                    dec_imm = XLEN'(instr[19:15]);  // CSR uimm is zero-extended
                end
            end
            default: begin
                dec_imm = '0;
                dec_fmt = FmtNone;
                dec_ill = 1'b1;
            end
        endcase
    end

    // 2-entry FIFO
    logic [XLEN-1:0] imm_q [2];
    logic [2:0]      fmt_q [2];
    logic            ill_q [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            in_ready;
    logic            out_valid;
    logic            push;
    logic            pop;

    // Ready depends only on the registered count, never on out_ready_i.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid_i && in_ready;
    assign pop       = out_valid && bus.out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: it is only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            imm_q[wr_ptr_q] <= dec_imm;
            fmt_q[wr_ptr_q] <= dec_fmt;
            ill_q[wr_ptr_q] <= dec_ill;
        end
    end

    always_comb begin
        bus.in_ready_o  = in_ready;
        bus.out_valid_o = out_valid;
        bus.imm_o       = '0;
        bus.fmt_o       = FmtNone;
        bus.illegal_o   = 1'b0;
        if (out_valid) begin
            bus.imm_o     = imm_q[rd_ptr_q];
            bus.fmt_o     = fmt_q[rd_ptr_q];
            bus.illegal_o = ill_q[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: runs an XLEN=32 and an XLEN=64 instance side by side on the
// same stimulus; a queue of pending instruction words plus an arithmetic
// immediate model supplies every expected output.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32)) if32 ();
    imm_gen_stage_if #(.XLEN(64)) if64 ();

    assign if32.in_valid_i  = in_valid;
    assign if32.out_ready_i = out_ready;
    assign if32.instr_i     = instr;
    assign if64.in_valid_i  = in_valid;
    assign if64.out_ready_i = out_ready;
    assign if64.instr_i     = instr;

    imm_gen_stage #(.XLEN(32), .ZIMM_EN(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    imm_gen_stage #(.XLEN(64), .ZIMM_EN(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    int errors = 0;
    int checks = 0;
    logic [31:0] mq[$];  // instruction words currently held by the stage, oldest first

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] w, input int sh);
        logic signed [63:0] s;
        s = {{32{w[31]}}, w};
        s = s >>> sh;
        return s;
    endfunction

    // Immediate built field by field with shifts on the sign-extended word.
    task automatic model(input logic [31:0] w, output logic [63:0] imm, output logic [2:0] fmt,
                         output logic ill);
        imm = 64'd0;
        fmt = 3'd7;
        ill = 1'b1;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin fmt = 3'd0; ill = 1'b0; imm = sx(w, 20); end
            7'h23: begin
                fmt = 3'd1; ill = 1'b0;
                imm = (sx(w, 25) << 5) | 64'(w[11:7]);
            end
            7'h63: begin
                fmt = 3'd2; ill = 1'b0;
                imm = (sx(w, 31) << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5)
                    | (64'(w[11:8]) << 1);
            end
            7'h37, 7'h17: begin fmt = 3'd3; ill = 1'b0; imm = sx(w, 0) & ~64'hFFF; end
            7'h6F: begin
                fmt = 3'd4; ill = 1'b0;
                imm = (sx(w, 31) << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11)
                    | (64'(w[30:21]) << 1);
            end
            7'h73: begin fmt = 3'd5; ill = 1'b0; imm = 64'(w[19:15]); end
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag);
        logic [63:0] eimm;
        logic [2:0]  efmt;
        logic        eill;
        if (mq.size() > 0) begin
            model(mq[0], eimm, efmt, eill);
        end else begin
            eimm = 64'd0; efmt = 3'd7; eill = 1'b0;
        end
        chk({tag, ".ready32"}, 64'(if32.in_ready_o), 64'(mq.size() != 2));
        chk({tag, ".valid32"}, 64'(if32.out_valid_o), 64'(mq.size() != 0));
        chk({tag, ".imm32"}, 64'(if32.imm_o), {32'd0, eimm[31:0]});
        chk({tag, ".fmt32"}, 64'(if32.fmt_o), 64'(efmt));
        chk({tag, ".ill32"}, 64'(if32.illegal_o), 64'(eill));
        chk({tag, ".ready64"}, 64'(if64.in_ready_o), 64'(mq.size() != 2));
        chk({tag, ".valid64"}, 64'(if64.out_valid_o), 64'(mq.size() != 0));
        chk({tag, ".imm64"}, if64.imm_o, eimm);
        chk({tag, ".fmt64"}, 64'(if64.fmt_o), 64'(efmt));
        chk({tag, ".ill64"}, 64'(if64.illegal_o), 64'(eill));
    endtask

    // One clock: update the model from the inputs held across the edge, then check.
    task automatic cycle(input string tag);
        bit push, pop;
        push = in_valid && (mq.size() < 2);
        pop  = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(instr);
        #1;
        check_state(tag);
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, ".imm32"}, 64'(if32.imm_o), {32'd0, v.imm});
        chk({tag, ".imm64"}, if64.imm_o, {{32{v.imm[31]}}, v.imm});
        chk({tag, ".fmt"}, 64'(if32.fmt_o), 64'(v.fmt));
        chk({tag, ".ill"}, 64'(if32.illegal_o), 64'(v.ill));
    endtask

    logic [6:0] ops[10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F};

    initial begin
        vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0};  // addi x1,x0,-1
        vecs[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd1, 1'b0};  // sw x1,-4(x2)
        vecs[2] = '{32'h123452B7, 32'h12345000, 3'd3, 1'b0};  // lui
        vecs[3] = '{32'h800002B7, 32'h80000000, 3'd3, 1'b0};  // lui x5,0x80000
        vecs[4] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};  // unknown opcode
        vecs[5] = '{32'h3401D073, 32'h00000003, 3'd5, 1'b0};  // csrwi, uimm=3
        vecs[6] = '{32'hFE000FE3, 32'hFFFFFFFE, 3'd2, 1'b0};  // beq x0,x0,-2
        vecs[7] = '{32'h008000EF, 32'h00000008, 3'd4, 1'b0};  // jal x1,8

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
        #2;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: push one, see it one edge later, drain it.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; instr = vecs[i].instr;
            cycle("tbl");
            chk_vec($sformatf("tbl%0d", i), vecs[i]);
            in_valid = 1'b0; instr = 32'hDEADBEEF;  // ignored: no push
            cycle("tbl_drain");
        end

        // Backpressure: three offered with out_ready low, third must be held.
        out_ready = 1'b0; in_valid = 1'b1;
        instr = vecs[0].instr; cycle("bp1");
        instr = vecs[1].instr; cycle("bp2");
        chk("bp.full_ready", 64'(if32.in_ready_o), 64'd0);
        instr = vecs[2].instr; cycle("bp3");
        chk_vec("bp.hold_head", vecs[0]);
        out_ready = 1'b1; cycle("bp4");
        chk_vec("bp.second", vecs[1]);
        cycle("bp5");
        chk_vec("bp.third", vecs[2]);
        in_valid = 1'b0; cycle("bp6");
        chk("bp.empty", 64'(if32.out_valid_o), 64'd0);

        // Asynchronous reset while full, between clock edges.
        out_ready = 1'b0; in_valid = 1'b1;
        instr = vecs[5].instr; cycle("rf1");
        instr = vecs[6].instr; cycle("rf2");
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        mq.delete();
        #1;
        check_state("rst_async");
        @(posedge clk);
        #1;
        check_state("rst_hold");
        #3;
        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; instr = vecs[7].instr;
        cycle("resume");
        chk_vec("resume.head", vecs[7]);
        in_valid = 1'b0; cycle("resume_drain");

        // Randomized traffic against the queue model.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 9)];
            instr     = w;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter: ZIMM_EN, 1, enables CSR-immediate (Z-type) decode for SYSTEM opcode 1110011.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: in_valid_i  input  1  upstream instruction valid.
REQ-006 SHALL have port: in_ready_o  output  1  stage can accept an instruction.
REQ-007 SHALL have port: instr_i  input  32  RV32/RV64 base instruction word.
REQ-008 SHALL have port: out_valid_o  output  1  head entry valid.
REQ-009 SHALL have port: out_ready_i  input  1  downstream accepts head entry.
REQ-010 SHALL have port: imm_o  output  XLEN  sign-extended immediate of head entry.
REQ-011 SHALL have port: fmt_o  output  3  format of head entry: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7.
REQ-012 SHALL have port: illegal_o  output  1  head entry opcode not recognised.

Function
REQ-013 SHALL decode opcode instr_i[6:0]: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 1110011 with ZIMM_EN=1 -> Z; anything else -> NONE.
REQ-014 SHALL form I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
REQ-015 SHALL form U = sext({instr[31:12],12'b0}) to XLEN (upper 32 bits copy instr[31] when XLEN=64).
REQ-016 SHALL form Z = zero-extended instr[19:15] (uimm), never sign-extended.
REQ-017 SHALL, for NONE, produce imm 0, fmt 7, illegal 1; illegal SHALL be 0 for every other format.
REQ-018 SHALL buffer decoded results in a 2-entry FIFO (count 0,1,2); decode occurs before storage, storage holds {imm, fmt, illegal}.
REQ-019 SHALL accept (push) when in_valid_i && in_ready_o at a rising edge; SHALL pop when out_valid_o && out_ready_i.
REQ-020 SHALL drive in_ready_o = (count != 2), from registered count only (no combinational path from out_ready_i).
REQ-021 SHALL drive out_valid_o = (count != 0); imm_o/fmt_o/illegal_o SHALL show the oldest entry and remain stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL have latency 1: instruction pushed at edge N into empty stage is on outputs with out_valid_o=1 after edge N.
REQ-023 SHALL, on simultaneous push and pop at count 1, keep count 1 and present the new entry after the edge; at count 2 no push occurs (in_ready_o=0).
REQ-024 SHALL preserve strict FIFO order; sustained throughput 1 instruction/cycle when out_ready_i=1.
REQ-025 SHALL, when count=0, drive imm_o=0, fmt_o=7, illegal_o=0.
REQ-026 SHALL ignore instr_i when no push occurs; pointers wrap modulo 2.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously, including mid-transfer), clear count and pointers: out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=7, illegal_o=0; buffered entries discarded.
REQ-028 SHALL resume accepting on the first rising edge after rst_n returns high.

Verification
REQ-029 SHALL cover: push 0xFFF00093 (addi x1,x0,-1), out_ready_i=1 -> next cycle imm_o=0xFFFFFFFF, fmt_o=0, illegal_o=0.
REQ-030 SHALL cover: push 0xFE112E23 (sw x1,-4(x2)) -> imm_o=0xFFFFFFFC, fmt_o=1; push 0x123452B7 (lui) -> imm_o=0x12345000, fmt_o=3.
REQ-031 SHALL cover: XLEN=64, push 0x800002B7 (lui x5,0x80000) -> imm_o=0xFFFFFFFF80000000, fmt_o=3.
REQ-032 SHALL cover: out_ready_i=0, offer 3 instructions back-to-back -> first two accepted, in_ready_o=0 after 2nd, 3rd held; raise out_ready_i -> three results in order, no loss.
REQ-033 SHALL cover: push 0x0000007F -> imm_o=0, fmt_o=7, illegal_o=1; push 0x3401D073 (csrwi, ZIMM_EN=1) -> imm_o=3, fmt_o=5.
REQ-034 SHALL cover: count=2, drop rst_n between edges -> out_valid_o=0, in_ready_o=1 immediately, before next clock edge.
